// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM states and the
// halfword geometry used to decide instruction length.
package instruction_sequencer_pkg;

  // IDLE: nothing held; HALF: first halfword of a 32-bit insn held;
  // FULL: a complete instruction is presented to decode.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    FULL = 2'd2
  } seq_state_e;

  // Width of one fetched halfword.
  localparam int HWORD_W = 16;

  // Bit of the first halfword that marks a 32-bit instruction.
  localparam int LONG_BIT = 15;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Fetch / flush / decode signal bundle for the instruction sequencer.
// master: the fetch unit / decoder / redirect side that drives the sequencer.
// slave : the sequencer itself.
interface instruction_sequencer_if #(
  parameter int PC_W = 24
) ();

  // fetch side
  logic [15:0]     fetch_word;
  logic            fetch_valid;
  logic            fetch_ready;

  // redirect
  logic            flush;
  logic [PC_W-1:0] flush_pc;

  // decode side
  logic            decode_valid;
  logic            decode_ready;
  logic [31:0]     decode_insn;
  logic            decode_is32;
  logic [PC_W-1:0] decode_pc;
  logic            decode_illegal;

  modport master (
    output fetch_word,
    output fetch_valid,
    input  fetch_ready,
    output flush,
    output flush_pc,
    input  decode_valid,
    output decode_ready,
    input  decode_insn,
    input  decode_is32,
    input  decode_pc,
    input  decode_illegal
  );

  modport slave (
    input  fetch_word,
    input  fetch_valid,
    output fetch_ready,
    input  flush,
    input  flush_pc,
    output decode_valid,
    input  decode_ready,
    output decode_insn,
    output decode_is32,
    output decode_pc,
    output decode_illegal
  );

endinterface

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: assembles 16-bit fetched halfwords into 16- or
// 32-bit instructions and presents them one at a time to the decoder.
// Bit 15 of a first halfword selects a 32-bit instruction; the second
// halfword's bit 15 never affects length.
// Optional feature macro: SEQ_ILLEGAL_CHECK_EN -- flags a 32-bit pair whose
// second halfword has bit 15 set (the instruction is still presented).
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int PC_W = 24
) (
  input logic                   clock,
  input logic                   reset_n,
  instruction_sequencer_if.slave bus
);

  seq_state_e           state_reg;
  logic [PC_W-1:0]      pc_reg;
  logic [PC_W-1:0]      dpc_reg;
  logic [HWORD_W-1:0]   lo_reg;
  logic [HWORD_W-1:0]   hi_reg;
  logic                 is32_reg;

  logic                 fetch_ready_int;
  logic                 fetch_xfer;
  logic                 decode_xfer;
  logic [PC_W-1:0]      pc_inc;

  // Ready is a decode of registered state plus the flush input only; the
  // decoder's ready never reaches fetch_ready. Held low while in reset.
  assign fetch_ready_int = reset_n & (state_reg != FULL) & ~bus.flush;
  assign fetch_xfer      = bus.fetch_valid & fetch_ready_int;
  assign decode_xfer     = (state_reg == FULL) & bus.decode_ready;
  assign pc_inc          = pc_reg + PC_W'(1);

  // Sequencer FSM with registered PC and instruction/output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      dpc_reg   <= '0;
      lo_reg    <= '0;
      hi_reg    <= '0;
      is32_reg  <= 1'b0;
    end else if (bus.flush) begin
      // Redirect wins over everything; a decode transfer in the same cycle
      // is simply dropped along with the rest of the held instruction.
      state_reg <= IDLE;
      pc_reg    <= bus.flush_pc;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fetch_xfer) begin
            pc_reg   <= pc_inc;
            dpc_reg  <= pc_reg;
            lo_reg   <= bus.fetch_word;
            hi_reg   <= '0;
            is32_reg <= 1'b0;
            state_reg <= bus.fetch_word[LONG_BIT] ? HALF : FULL;
          end
        end
        HALF: begin
          if (fetch_xfer) begin
            pc_reg    <= pc_inc;
            hi_reg    <= bus.fetch_word;
            is32_reg  <= 1'b1;
            state_reg <= FULL;
          end
        end
        FULL: begin
          if (decode_xfer) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SEQ_ILLEGAL_CHECK_EN
  logic illegal_reg;

  // Flag a 32-bit pair whose second halfword also carries the long marker.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      illegal_reg <= 1'b0;
    end else if (bus.flush) begin
      illegal_reg <= 1'b0;
    end else if (fetch_xfer && (state_reg == HALF)) begin
      illegal_reg <= bus.fetch_word[LONG_BIT];
    end else if (fetch_xfer && (state_reg == IDLE)) begin
      illegal_reg <= 1'b0;
    end
  end

  assign bus.decode_illegal = illegal_reg;
`else
  assign bus.decode_illegal = 1'b0;
`endif

  assign bus.fetch_ready  = fetch_ready_int;
  assign bus.decode_valid = (state_reg == FULL);
  assign bus.decode_insn  = {hi_reg, lo_reg};
  assign bus.decode_is32  = is32_reg;
  assign bus.decode_pc    = dpc_reg;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed scenarios followed
// by a randomized run, all checked against a halfword-stream reference model.
module tb_instruction_sequencer;

  localparam int PC_W = 24;

`ifdef SEQ_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clock;
  logic reset_n;

  instruction_sequencer_if #(.PC_W(PC_W)) bus ();

  instruction_sequencer #(.PC_W(PC_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: queue of complete instructions awaiting the decoder,
  // plus any pending first halfword of a 32-bit instruction.
  typedef struct {
    logic [31:0]     insn;
    logic            is32;
    logic [PC_W-1:0] pc;
    logic            ill;
  } insn_t;

  insn_t           q[$];
  bit              have_half;
  logic [15:0]     half_w;
  logic [PC_W-1:0] half_pc;
  logic [PC_W-1:0] m_pc;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input logic [PC_W-1:0] new_pc);
    q.delete();
    have_half = 1'b0;
    m_pc = new_pc;
  endtask

  task automatic model_accept(input logic [15:0] w);
    insn_t e;
    if (!have_half) begin
      if (w[15]) begin
        have_half = 1'b1;
        half_w    = w;
        half_pc   = m_pc;
      end else begin
        e.insn = {16'h0000, w};
        e.is32 = 1'b0;
        e.pc   = m_pc;
        e.ill  = 1'b0;
        q.push_back(e);
      end
    end else begin
      e.insn = {w, half_w};
      e.is32 = 1'b1;
      e.pc   = half_pc;
      e.ill  = ILL_EN & w[15];
      q.push_back(e);
      have_half = 1'b0;
    end
    m_pc = m_pc + PC_W'(1);
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by what the coming rising edge will transfer.
  task automatic step(input bit fv, input logic [15:0] fw, input bit dr,
                      input bit fl, input logic [PC_W-1:0] fpc);
    bit exp_ready;
    @(negedge clock);
    bus.fetch_valid  = fv;
    bus.fetch_word   = fw;
    bus.decode_ready = dr;
    bus.flush        = fl;
    bus.flush_pc     = fpc;
    #1;
    exp_ready = !fl && (q.size() == 0);
    check("fetch_ready", 32'(bus.fetch_ready), 32'(exp_ready));
    check("decode_valid", 32'(bus.decode_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("decode_insn", bus.decode_insn, q[0].insn);
      check("decode_is32", 32'(bus.decode_is32), 32'(q[0].is32));
      check("decode_pc", 32'(bus.decode_pc), 32'(q[0].pc));
      check("decode_illegal", 32'(bus.decode_illegal), 32'(q[0].ill));
    end
    if (q.size() != 0 && dr) void'(q.pop_front());
    if (fl) model_clear(fpc);
    else if (fv && exp_ready) model_accept(fw);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.fetch_ready), 32'd0);
    check({tag, "_valid"}, 32'(bus.decode_valid), 32'd0);
    check({tag, "_insn"}, bus.decode_insn, 32'd0);
    check({tag, "_is32"}, 32'(bus.decode_is32), 32'd0);
    check({tag, "_pc"}, 32'(bus.decode_pc), 32'd0);
    check({tag, "_ill"}, 32'(bus.decode_illegal), 32'd0);
  endtask

  // Asynchronous reset pulse between clock edges, released on a falling edge.
  task automatic do_reset();
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    bus.fetch_valid  = 1'b1;
    bus.fetch_word   = 16'h0011;
    bus.decode_ready = 1'b0;
    bus.flush        = 1'b0;
    bus.flush_pc     = '0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clock);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clock);
    reset_n = 1'b1;
    bus.fetch_valid = 1'b0;
    model_clear('0);
    #1;
    check("rst_release_ready", 32'(bus.fetch_ready), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.fetch_valid  = 1'b0;
    bus.fetch_word   = '0;
    bus.decode_ready = 1'b0;
    bus.flush        = 1'b0;
    bus.flush_pc     = '0;
    model_clear('0);

    // 16-bit instruction right after reset
    do_reset();
    step(1, 16'h1234, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("r033_valid", 32'(bus.decode_valid), 32'd1);
    check("r033_insn", bus.decode_insn, 32'h0000_1234);
    check("r033_is32", 32'(bus.decode_is32), 32'd0);
    check("r033_pc", 32'(bus.decode_pc), 32'd0);

    // 32-bit pair then a 16-bit instruction at pc 2
    do_reset();
    step(1, 16'h8001, 1, 0, '0);
    step(1, 16'h0002, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("r034_insn", bus.decode_insn, 32'h0002_8001);
    check("r034_is32", 32'(bus.decode_is32), 32'd1);
    check("r034_pc", 32'(bus.decode_pc), 32'd0);
    step(1, 16'h0003, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("r034_next_pc", 32'(bus.decode_pc), 32'd2);

    // decoder stall for 5 cycles, then release
    step(1, 16'h0055, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1, 16'h0066, 0, 0, '0);
      check("r035_hold_insn", bus.decode_insn, 32'h0000_0055);
    end
    step(1, 16'h0077, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("r035_idle_after", 32'(bus.decode_valid), 32'd0);

    // flush while holding a first halfword
    step(1, 16'h8123, 1, 0, '0);
    step(1, 16'h0999, 1, 1, 24'h000100);
    step(1, 16'h0042, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("r036_pc", 32'(bus.decode_pc), 32'h0000_0100);
    check("r036_insn", bus.decode_insn, 32'h0000_0042);

    // PC wrap
    step(0, 16'h0000, 1, 1, 24'hFFFFFF);
    step(1, 16'h0001, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("r037_pc_top", 32'(bus.decode_pc), 32'h00FF_FFFF);
    step(1, 16'h0002, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("r037_pc_wrap", 32'(bus.decode_pc), 32'd0);

    // malformed 32-bit pair
    step(1, 16'h8000, 1, 0, '0);
    step(1, 16'h8000, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("r038_valid", 32'(bus.decode_valid), 32'd1);
    check("r038_is32", 32'(bus.decode_is32), 32'd1);
    check("r038_illegal", 32'(bus.decode_illegal), 32'(ILL_EN));

    // flush coinciding with a decode transfer
    step(1, 16'h0abc, 1, 0, '0);
    step(0, 16'h0000, 1, 1, 24'h000020);
    step(1, 16'h0def, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("flush_dec_pc", 32'(bus.decode_pc), 32'h0000_0020);

    // reset in the middle of a 32-bit instruction
    step(1, 16'h8777, 1, 0, '0);
    do_reset();
    step(1, 16'h0101, 1, 0, '0);
    step(0, 16'h0000, 1, 0, '0);
    check("midrst_pc", 32'(bus.decode_pc), 32'd0);
    check("midrst_insn", bus.decode_insn, 32'h0000_0101);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rfv, rdr, rfl;
      logic [15:0] rw;
      logic [PC_W-1:0] rpc;
      rfv = ($urandom_range(0, 9) < 7);
      rdr = ($urandom_range(0, 9) < 6);
      rfl = ($urandom_range(0, 19) == 0);
      rw  = 16'($urandom);
      rpc = ($urandom_range(0, 2) == 0) ? (24'hFFFFFD + PC_W'($urandom_range(0, 2)))
                                        : PC_W'($urandom);
      step(rfv, rw, rdr, rfl, rpc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
